// File: rtl/var_deshift.sv
// Serial-in, parallel-out receiver: collects 1..WIDTH bits MSB- or LSB-first into a right-aligned word.
// Optional sign extension of the received word is enabled by defining VAR_DESHIFT_SIGN_EXT_EN.
module var_deshift #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             dir,
   input  logic             sin,
   input  logic             sin_valid,
   output logic             busy,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             err
);

   typedef enum logic {IDLE, COLLECT} state_t;

   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             qv_q, qv_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] acc_nxt;
   logic             len_ok;
   logic             last_bit;

   // Bits at and above n get the fill bit: zero by default, bit n-1 when sign extension is built in.
   function automatic logic [WIDTH-1:0] fill_upper(input logic [WIDTH-1:0] w,
                                                   input logic [CNT_W-1:0] n);
      logic [WIDTH-1:0] r;
      logic             fill;
      r    = w;
      fill = 1'b0;
`ifdef VAR_DESHIFT_SIGN_EXT_EN
      for (int i = 0; i < WIDTH; i++)
         if (i == int'(n) - 1) fill = w[i];
`endif
      for (int i = 0; i < WIDTH; i++)
         if (i >= int'(n)) r[i] = fill;
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      word_d  = word_q;
      qv_d    = 1'b0;
      err_d   = 1'b0;

      len_ok   = (len != '0) && (len <= LEN_MAX);
      last_bit = ((cnt_q + CNT_W'(1)) == len_q);
      // MSB-first shifts left so the first bit ends at len-1; LSB-first drops each bit at its index.
      acc_nxt  = dir_q ? (acc_q | (WIDTH'(sin) << cnt_q)) : {acc_q[WIDTH-2:0], sin};

      if (en) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     state_d = COLLECT;
                     len_d   = len;
                     dir_d   = dir;
                     cnt_d   = '0;
                     acc_d   = '0;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (sin_valid) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  acc_d = acc_nxt;
                  if (last_bit) begin
                     word_d  = fill_upper(acc_nxt, len_q);
                     qv_d    = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         len_q   <= '0;
         dir_q   <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         word_q  <= '0;
         qv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         word_q  <= word_d;
         qv_q    <= qv_d;
         err_q   <= err_d;
      end
   end

   assign busy    = (state_q == COLLECT);
   assign q       = word_q;
   assign q_valid = qv_q;
   assign err     = err_q;

endmodule
